// File: rtl/ahb_lite_cmd_master.sv
// ---------------------------------------------------------------------------
// ahb_lite_cmd_master
//
// AHB-Lite bus master that turns a valid/ready command stream into single
// AHB-Lite transfers (one outstanding transfer) and returns the read data and
// error status on a valid/ready response channel. It sits beside the core on
// the system bus and is used to load memories and poke peripherals.
//
// Parameters
//   HPROT_VAL    constant driven on HPROT
//   CHECK_ALIGN  1: reject illegal size/alignment locally, 0: issue as given
//
// Ports
//   HCLK, HRESETn             bus clock, asynchronous active-low reset
//   cmd_valid/cmd_ready       command handshake
//   cmd_write/addr/size/wdata command fields (wdata right-justified)
//   rsp_valid/rsp_ready       response handshake
//   rsp_rdata, rsp_err        read data (right-justified, zero-extended), error
//   HADDR..HMASTLOCK, HWDATA  AHB-Lite master outputs
//   HRDATA, HREADY, HRESP     AHB-Lite slave responses
//
// Flow: IDLE -> ADDR -> DATA -> RESP -> IDLE. Every output is a register, so
// a zero-wait transfer takes four cycles from accept to the next accept.
// ---------------------------------------------------------------------------
module ahb_lite_cmd_master #(
    parameter logic [3:0] HPROT_VAL   = 4'b0011,
    parameter bit         CHECK_ALIGN = 1'b1
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [31:0] cmd_addr,
    input  logic [2:0]  cmd_size,
    input  logic [31:0] cmd_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [31:0] HADDR,
    output logic [1:0]  HTRANS,
    output logic        HWRITE,
    output logic [2:0]  HSIZE,
    output logic [2:0]  HBURST,
    output logic [3:0]  HPROT,
    output logic        HMASTLOCK,
    output logic [31:0] HWDATA,
    input  logic [31:0] HRDATA,
    input  logic        HREADY,
    input  logic        HRESP
);

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_DATA = 2'd2,
        S_RESP = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic        cmd_ready_q, cmd_ready_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic        rsp_err_q, rsp_err_d;
    logic [1:0]  htrans_q, htrans_d;
    logic [31:0] haddr_q, haddr_d;
    logic        hwrite_q, hwrite_d;
    logic [2:0]  hsize_q, hsize_d;
    logic [31:0] hwdata_q, hwdata_d;
    logic [31:0] wdata_q, wdata_d;

    // Size above word, or an address not aligned to the transfer size.
    function automatic logic is_illegal(input logic [1:0] a, input logic [2:0] sz);
        return (sz > 3'd2) || ((sz == 3'd1) && a[0]) || ((sz == 3'd2) && (a != 2'b00));
    endfunction

    // Replicate the right-justified write data onto every byte lane it may hit.
    function automatic logic [31:0] write_lanes(input logic [2:0] sz, input logic [31:0] d);
        logic [31:0] r;
        case (sz)
            3'd0:    r = {4{d[7:0]}};
            3'd1:    r = {2{d[15:0]}};
            default: r = d;
        endcase
        return r;
    endfunction

    // Pick the addressed lane out of HRDATA and right-justify it (little-endian).
    function automatic logic [31:0] read_lane(input logic [1:0] a, input logic [2:0] sz,
                                              input logic [31:0] d);
        logic [31:0] byte_sh;
        logic [31:0] half_sh;
        logic [31:0] r;
        byte_sh = d >> {a, 3'b000};
        half_sh = d >> {a[1], 4'b0000};
        case (sz)
            3'd0:    r = {24'h0, byte_sh[7:0]};
            3'd1:    r = {16'h0, half_sh[15:0]};
            default: r = d;
        endcase
        return r;
    endfunction

    always_comb begin
        // NOTE: every next-state value starts as a copy of its register so no
        // path through the case statement can leave one unassigned (no latches).
        state_d     = state_q;
        cmd_ready_d = cmd_ready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        htrans_d    = htrans_q;
        haddr_d     = haddr_q;
        hwrite_d    = hwrite_q;
        hsize_d     = hsize_q;
        hwdata_d    = hwdata_q;
        wdata_d     = wdata_q;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    cmd_ready_d = 1'b0;
                    wdata_d     = cmd_wdata;
                    if (CHECK_ALIGN && is_illegal(cmd_addr[1:0], cmd_size)) begin
                        // Rejected locally: answer straight away, bus stays idle.
                        state_d     = S_RESP;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                        rsp_rdata_d = '0;
                    end else begin
                        state_d  = S_ADDR;
                        htrans_d = HTRANS_NONSEQ;
                        haddr_d  = cmd_addr;
                        hwrite_d = cmd_write;
                        hsize_d  = cmd_size;
                    end
                end
            end
            S_ADDR: begin
                // The address phase completes only when the bus is ready.
                if (HREADY) begin
                    state_d  = S_DATA;
                    htrans_d = HTRANS_IDLE;
                    if (hwrite_q) begin
                        hwdata_d = write_lanes(hsize_q, wdata_q);
                    end
                end
            end
            S_DATA: begin
                // HREADY low (plain wait or first error cycle) holds everything.
                if (HREADY) begin
                    state_d     = S_RESP;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = HRESP;
                    rsp_rdata_d = (!hwrite_q && !HRESP) ? read_lane(haddr_q[1:0], hsize_q, HRDATA)
                                                        : '0;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d     = S_IDLE;
                    rsp_valid_d = 1'b0;
                    cmd_ready_d = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Every register, including the command latch, returns to a known value so
    // a reset in the middle of a transfer leaves nothing half-issued.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q     <= S_IDLE;
            cmd_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            htrans_q    <= HTRANS_IDLE;
            haddr_q     <= '0;
            hwrite_q    <= 1'b0;
            hsize_q     <= '0;
            hwdata_q    <= '0;
            wdata_q     <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, independent of statement order.
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            htrans_q    <= htrans_d;
            haddr_q     <= haddr_d;
            hwrite_q    <= hwrite_d;
            hsize_q     <= hsize_d;
            hwdata_q    <= hwdata_d;
            wdata_q     <= wdata_d;
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign HTRANS    = htrans_q;
    assign HADDR     = haddr_q;
    assign HWRITE    = hwrite_q;
    assign HSIZE     = hsize_q;
    assign HWDATA    = hwdata_q;
    assign HBURST    = 3'b000;
    assign HPROT     = HPROT_VAL;
    assign HMASTLOCK = 1'b0;

endmodule

// File: tb/tb_ahb_lite_cmd_master.sv
// ---------------------------------------------------------------------------
// Self-checking bench for ahb_lite_cmd_master. The bench plays the AHB slave
// and the command/response user; expected bus and response values come from
// a small behavioural model of the transfer rules.
// ---------------------------------------------------------------------------
module tb_ahb_lite_cmd_master;

    logic        HCLK;
    logic        HRESETn;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [2:0]  cmd_size;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic [3:0]  HPROT;
    logic        HMASTLOCK;
    logic [31:0] HWDATA;
    logic [31:0] HRDATA;
    logic        HREADY;
    logic        HRESP;

    int n_checks = 0;
    int n_errors = 0;

    ahb_lite_cmd_master #(
        .HPROT_VAL   (4'b0011),
        .CHECK_ALIGN (1'b1)
    ) dut (
        .HCLK      (HCLK),
        .HRESETn   (HRESETn),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_size  (cmd_size),
        .cmd_wdata (cmd_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .HADDR     (HADDR),
        .HTRANS    (HTRANS),
        .HWRITE    (HWRITE),
        .HSIZE     (HSIZE),
        .HBURST    (HBURST),
        .HPROT     (HPROT),
        .HMASTLOCK (HMASTLOCK),
        .HWDATA    (HWDATA),
        .HRDATA    (HRDATA),
        .HREADY    (HREADY),
        .HRESP     (HRESP)
    );

    initial begin
        HCLK = 1'b0;
        forever #5 HCLK = ~HCLK;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic bit model_illegal(input logic [31:0] addr, input logic [2:0] size);
        int a;
        a = int'(addr[1:0]);
        if (size > 3'd2) return 1'b1;
        if (size == 3'd1 && (a % 2) != 0) return 1'b1;
        if (size == 3'd2 && a != 0) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] model_lanes(input logic [2:0] size, input logic [31:0] d);
        if (size == 3'd0) return {24'h0, d[7:0]} * 32'h0101_0101;
        if (size == 3'd1) return {16'h0, d[15:0]} * 32'h0001_0001;
        return d;
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] addr, input logic [2:0] size,
                                               input logic [31:0] d);
        int          nbytes;
        int          off;
        logic [31:0] mask;
        nbytes = (size == 3'd0) ? 1 : (size == 3'd1) ? 2 : 4;
        off    = (int'(addr[1:0]) / nbytes) * nbytes;
        mask   = (nbytes == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nbytes)) - 32'd1);
        return (d >> (8 * off)) & mask;
    endfunction

    // ---------------- one complete command/response ----------------
    task automatic do_txn(input string name, input logic wr, input logic [31:0] addr,
                          input logic [2:0] size, input logic [31:0] wdata,
                          input logic [31:0] slave_rdata, input int addr_waits,
                          input int data_waits, input bit slave_err, input int hold);
        bit          illegal;
        bit          seen;
        int          guard;
        logic        exp_err;
        logic [31:0] exp_rdata;
        logic [31:0] exp_wd;

        if (slave_err && data_waits < 1) data_waits = 1;
        illegal = model_illegal(addr, size);

        guard = 0;
        while (cmd_ready !== 1'b1 && guard < 20) begin
            @(posedge HCLK); #1;
            guard++;
        end
        n_checks++;
        if (cmd_ready !== 1'b1) begin
            $display("FAIL %s idle: cmd_ready=%b required 1", name, cmd_ready);
            n_errors++;
        end

        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_size  = size;
        cmd_wdata = wdata;
        HREADY    = 1'b1;
        HRESP     = 1'b0;
        rsp_ready = 1'b0;
        @(posedge HCLK); #1;
        // Scramble the command inputs so a DUT that fails to latch shows it.
        cmd_valid = 1'b0;
        cmd_addr  = $urandom;
        cmd_wdata = $urandom;
        cmd_write = ~wr;

        if (illegal) begin
            seen = 1'b0;
            for (int c = 1; c <= 2 && !seen; c++) begin
                n_checks++;
                if (HTRANS !== 2'b00 || cmd_ready !== 1'b0) begin
                    $display("FAIL %s reject: HTRANS=%b cmd_ready=%b required 00/0", name,
                             HTRANS, cmd_ready);
                    n_errors++;
                end
                if (rsp_valid === 1'b1) seen = 1'b1;
                else begin
                    @(posedge HCLK); #1;
                end
            end
            exp_err   = 1'b1;
            exp_rdata = '0;
        end else begin
            for (int c = 0; c <= addr_waits; c++) begin
                n_checks++;
                if ({HTRANS, HADDR, HWRITE, HSIZE, cmd_ready, rsp_valid} !==
                    {2'b10, addr, wr, size, 1'b0, 1'b0}) begin
                    $display("FAIL %s addr phase %0d: HTRANS=%b HADDR=%h HWRITE=%b HSIZE=%0d cmd_ready=%b rsp_valid=%b required 10 %h %b %0d 0 0",
                             name, c, HTRANS, HADDR, HWRITE, HSIZE, cmd_ready, rsp_valid,
                             addr, wr, size);
                    n_errors++;
                end
                HREADY = (c == addr_waits);
                @(posedge HCLK); #1;
            end
            exp_wd = model_lanes(size, wdata);
            for (int c = 0; c <= data_waits; c++) begin
                n_checks++;
                if (HTRANS !== 2'b00 || rsp_valid !== 1'b0 || (wr && HWDATA !== exp_wd)) begin
                    $display("FAIL %s data phase %0d: HTRANS=%b rsp_valid=%b HWDATA=%h required 00 0 %h",
                             name, c, HTRANS, rsp_valid, HWDATA, exp_wd);
                    n_errors++;
                end
                HREADY = (c == data_waits);
                HRESP  = slave_err && (c >= data_waits - 1);
                HRDATA = (c == data_waits) ? slave_rdata : $urandom;
                @(posedge HCLK); #1;
            end
            seen      = (rsp_valid === 1'b1);
            exp_err   = slave_err;
            exp_rdata = (wr || slave_err) ? 32'h0 : model_read(addr, size, slave_rdata);
        end
        HREADY = 1'b1;
        HRESP  = 1'b0;
        HRDATA = $urandom;

        n_checks++;
        if (!seen) begin
            $display("FAIL %s latency: rsp_valid=%b required 1", name, rsp_valid);
            n_errors++;
        end
        for (int h = 0; h <= hold; h++) begin
            n_checks++;
            if ({rsp_valid, rsp_err, rsp_rdata, cmd_ready, HTRANS} !==
                {1'b1, exp_err, exp_rdata, 1'b0, 2'b00}) begin
                $display("FAIL %s response %0d: valid=%b err=%b rdata=%h cmd_ready=%b HTRANS=%b required 1 %b %h 0 00",
                         name, h, rsp_valid, rsp_err, rsp_rdata, cmd_ready, HTRANS,
                         exp_err, exp_rdata);
                n_errors++;
            end
            rsp_ready = (h == hold);
            @(posedge HCLK); #1;
        end
        rsp_ready = 1'b0;
        n_checks++;
        if ({rsp_valid, cmd_ready} !== 2'b01) begin
            $display("FAIL %s release: rsp_valid=%b cmd_ready=%b required 0 1", name,
                     rsp_valid, cmd_ready);
            n_errors++;
        end
    endtask

    task automatic check_reset_values(input string name);
        n_checks++;
        if ({cmd_ready, rsp_valid, rsp_rdata, rsp_err, HTRANS, HADDR, HWRITE, HSIZE, HWDATA} !==
            {1'b1, 1'b0, 32'h0, 1'b0, 2'b00, 32'h0, 1'b0, 3'd0, 32'h0}) begin
            $display("FAIL %s: cmd_ready=%b rsp_valid=%b rdata=%h err=%b HTRANS=%b HADDR=%h HWRITE=%b HSIZE=%0d HWDATA=%h required reset values",
                     name, cmd_ready, rsp_valid, rsp_rdata, rsp_err, HTRANS, HADDR, HWRITE,
                     HSIZE, HWDATA);
            n_errors++;
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        HRESETn   = 1'b0;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_size  = '0;
        cmd_wdata = '0;
        rsp_ready = 1'b0;
        HRDATA    = '0;
        HREADY    = 1'b1;
        HRESP     = 1'b0;
        @(posedge HCLK); #1;
        @(posedge HCLK); #1;
        check_reset_values("reset");
        n_checks++;
        if ({HBURST, HPROT, HMASTLOCK} !== {3'b000, 4'b0011, 1'b0}) begin
            $display("FAIL reset constants: HBURST=%b HPROT=%b HMASTLOCK=%b required 000 0011 0",
                     HBURST, HPROT, HMASTLOCK);
            n_errors++;
        end
        HRESETn = 1'b1;
        @(posedge HCLK); #1;
        check_reset_values("idle after reset");
    endtask

    task automatic test_directed();
        do_txn("word write", 1'b1, 32'h2000_0000, 3'd2, 32'hDEAD_BEEF, 32'h0, 0, 0, 1'b0, 0);
        do_txn("byte read", 1'b0, 32'h0000_0103, 3'd0, 32'h0, 32'h1122_3344, 0, 0, 1'b0, 0);
        do_txn("half write waits", 1'b1, 32'h4000_0002, 3'd1, 32'h0000_ABCD, 32'h0, 0, 3, 1'b0, 0);
        do_txn("half read lane2", 1'b0, 32'h0000_0012, 3'd1, 32'h0, 32'hCAFE_F00D, 0, 0, 1'b0, 0);
        do_txn("error word read", 1'b0, 32'h0000_0020, 3'd2, 32'h0, 32'h5555_AAAA, 0, 1, 1'b1, 0);
        do_txn("addr phase wait", 1'b0, 32'h0000_0040, 3'd2, 32'h0, 32'h8765_4321, 2, 0, 1'b0, 0);
    endtask

    task automatic test_reject();
        do_txn("misaligned half", 1'b0, 32'h0000_0001, 3'd1, 32'h0, 32'h0, 0, 0, 1'b0, 0);
        do_txn("size 3", 1'b1, 32'h0000_0000, 3'd3, 32'h1234_5678, 32'h0, 0, 0, 1'b0, 0);
        do_txn("misaligned word", 1'b1, 32'h0000_0006, 3'd2, 32'h1234_5678, 32'h0, 0, 0, 1'b0, 0);
    endtask

    task automatic test_backpressure();
        do_txn("rsp hold 5", 1'b0, 32'h0000_0201, 3'd0, 32'h0, 32'hA1B2_C3D4, 0, 0, 1'b0, 5);
    endtask

    task automatic test_random();
        logic [31:0] addr;
        logic [2:0]  size;
        for (int i = 0; i < 40; i++) begin
            size = 3'($urandom_range(0, 3));
            addr = $urandom;
            if ($urandom_range(0, 3) != 0 && size <= 3'd2) begin
                addr = (addr >> size) << size;
            end
            do_txn($sformatf("random %0d", i), 1'($urandom_range(0, 1)), addr, size, $urandom,
                   $urandom, $urandom_range(0, 2), $urandom_range(0, 3),
                   ($urandom_range(0, 7) == 0), $urandom_range(0, 2));
        end
    endtask

    task automatic test_back_to_back();
        bit [12:1] got_rv;
        bit [12:1] got_ns;
        bit [12:1] exp_rv;
        bit [12:1] exp_ns;
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = 32'h2000_0100;
        cmd_size  = 3'd2;
        cmd_wdata = 32'h0BAD_F00D;
        rsp_ready = 1'b1;
        HREADY    = 1'b1;
        HRESP     = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            @(posedge HCLK); #1;
            got_rv[i] = (rsp_valid === 1'b1);
            got_ns[i] = (HTRANS === 2'b10);
            exp_rv[i] = ((i % 4) == 3);
            exp_ns[i] = ((i % 4) == 1);
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b0;
        n_checks++;
        if (got_rv !== exp_rv || got_ns !== exp_ns) begin
            $display("FAIL back to back: rsp_valid pattern=%b nonseq pattern=%b required %b %b",
                     got_rv, got_ns, exp_rv, exp_ns);
            n_errors++;
        end
        @(posedge HCLK); #1;
    endtask

    task automatic test_async_reset();
        n_checks++;
        if (cmd_ready !== 1'b1) begin
            $display("FAIL async reset setup: cmd_ready=%b required 1", cmd_ready);
            n_errors++;
        end
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = 32'h2000_0010;
        cmd_size  = 3'd2;
        cmd_wdata = 32'h1357_9BDF;
        HREADY    = 1'b1;
        @(posedge HCLK); #1;
        cmd_valid = 1'b0;
        @(posedge HCLK); #1;
        HREADY = 1'b0;
        n_checks++;
        if (HTRANS !== 2'b00 || HWDATA !== 32'h1357_9BDF) begin
            $display("FAIL async reset data phase: HTRANS=%b HWDATA=%h required 00 13579bdf",
                     HTRANS, HWDATA);
            n_errors++;
        end
        #2 HRESETn = 1'b0;
        #1;
        check_reset_values("async reset immediate");
        @(posedge HCLK); #1;
        check_reset_values("async reset held");
        HRESETn = 1'b1;
        HREADY  = 1'b1;
        do_txn("after reset", 1'b0, 32'h0000_0302, 3'd1, 32'h0, 32'hBEEF_1234, 0, 0, 1'b0, 0);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_reject();
        test_backpressure();
        test_back_to_back();
        test_random();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
